// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues aligned doubleword requests with byte strobes,
// formats load data into md, and stalls the pipeline while an access is outstanding.
module mem_access_unit #(
  parameter int XLEN  = 64,
  parameter int BYTES = XLEN / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  mr,
  input  logic [XLEN-1:0]  mqb,
  input  logic             mwmem,
  input  logic             mm2reg,
  input  logic [2:0]       mfunct3,
  input  logic             mvalid,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [BYTES-1:0] dmem_wstrb,
  output logic [XLEN-1:0]  md,
  output logic             mem_stall,
  output logic             misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [BYTES-1:0]  wstrb_q, wstrb_d;
  logic [XLEN-1:0]   md_q, md_d;
  logic              misalign_q, misalign_d;
  logic [2:0]        ld_off_q, ld_off_d;
  logic [2:0]        ld_funct3_q, ld_funct3_d;

  logic              access;
  logic              aligned;
  logic [BYTES-1:0]  strb_base;
  logic [XLEN-1:0]   rd_shifted;
  logic [XLEN-1:0]   ld_formatted;

  assign access = mvalid & (mwmem | mm2reg);

  always_comb begin
    aligned   = 1'b1;
    strb_base = 8'h01;
    case (mfunct3[1:0])
      2'b00: begin aligned = 1'b1;             strb_base = 8'h01; end
      2'b01: begin aligned = (mr[0] == 1'b0);   strb_base = 8'h03; end
      2'b10: begin aligned = (mr[1:0] == 2'b00); strb_base = 8'h0F; end
      default: begin aligned = (mr[2:0] == 3'b000); strb_base = 8'hFF; end
    endcase
  end

  // Load size/sign are latched at issue so formatting does not depend on upstream inputs.
  always_comb begin
    rd_shifted   = dmem_rdata >> {ld_off_q, 3'b000};
    ld_formatted = rd_shifted;
    case (ld_funct3_q)
      3'b000:  ld_formatted = {{56{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  ld_formatted = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b010:  ld_formatted = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
      3'b100:  ld_formatted = {56'd0, rd_shifted[7:0]};
      3'b101:  ld_formatted = {48'd0, rd_shifted[15:0]};
      3'b110:  ld_formatted = {32'd0, rd_shifted[31:0]};
      default: ld_formatted = rd_shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    md_d        = md_q;
    misalign_d  = 1'b0;
    ld_off_d    = ld_off_q;
    ld_funct3_d = ld_funct3_q;
    mem_stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            mem_stall   = 1'b1;
            req_d       = 1'b1;
            we_d        = mwmem;
            addr_d      = {mr[XLEN-1:3], 3'b000};
            wdata_d     = mqb << {mr[2:0], 3'b000};
            wstrb_d     = mwmem ? (strb_base << mr[2:0]) : 8'h00;
            ld_off_d    = mr[2:0];
            ld_funct3_d = mfunct3;
            state_d     = BUSY;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) md_d = ld_formatted;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      md_q        <= '0;
      misalign_q  <= 1'b0;
      ld_off_q    <= 3'b000;
      ld_funct3_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      md_q        <= md_d;
      misalign_q  <= misalign_d;
      ld_off_q    <= ld_off_d;
      ld_funct3_q <= ld_funct3_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  assign md         = md_q;
  assign misalign   = misalign_q;

endmodule
